// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath drives the *_i hazard inputs; the controller drives the *_o pipeline controls.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             idex_memread_i;
  logic [4:0]       idex_rd_i;
  logic [4:0]       ifid_rs_i;
  logic [4:0]       ifid_rt_i;
  logic             ifid_uses_rt_i;
  logic             branch_taken_i;
  logic             mul_start_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             if_flush_o;
  logic             idex_flush_o;
  logic             idex_hold_o;
  logic             exmem_flush_o;
  logic             mul_done_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output idex_memread_i, idex_rd_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, mul_start_i,
    input  pc_write_o, ifid_write_o, if_flush_o, idex_flush_o, idex_hold_o,
           exmem_flush_o, mul_done_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  idex_memread_i, idex_rd_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, mul_start_i,
    output pc_write_o, ifid_write_o, if_flush_o, idex_flush_o, idex_hold_o,
           exmem_flush_o, mul_done_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, multi-cycle
// multiply occupancy of EX, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipe_hazard_ctrl_if.slave    bus
);

  typedef enum logic {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;

  localparam int         MUL_LOAD_INT = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;
  localparam logic [3:0] MUL_LOAD     = MUL_LOAD_INT[3:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}}))
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  state_t           state, state_nxt;
  logic [3:0]       mul_cnt, mul_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             load_use;
  logic             flush_evt;
  logic             pc_write, ifid_write, if_flush, idex_flush;
  logic             idex_hold, exmem_flush, mul_done;

  assign load_use = bus.idex_memread_i && (bus.idex_rd_i != 5'd0) &&
                    ((bus.idex_rd_i == bus.ifid_rs_i) ||
                     (bus.ifid_uses_rt_i && (bus.idex_rd_i == bus.ifid_rt_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= RUN;
      mul_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mul_cnt_nxt = mul_cnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b0;
    if_flush    = 1'b0;
    idex_flush  = 1'b0;
    idex_hold   = 1'b0;
    exmem_flush = 1'b0;
    mul_done    = 1'b0;
    flush_evt   = 1'b0;
    // Reset forces the idle control pattern regardless of hazard inputs.
    if (!rst_i) begin
      unique case (state)
        RUN: begin
          if (bus.branch_taken_i) begin
            if_flush   = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
          end else begin
            if (bus.mul_start_i) begin
              if (MUL_CYCLES == 1) begin
                mul_done = 1'b1;
              end else begin
                state_nxt   = MUL_WAIT;
                mul_cnt_nxt = MUL_LOAD;
              end
            end
            if (load_use) begin
              pc_write   = 1'b0;
              ifid_write = 1'b1;
              idex_flush = 1'b1;
            end
          end
        end
        MUL_WAIT: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b1;
          idex_hold   = 1'b1;
          exmem_flush = 1'b1;
          if (mul_cnt == 4'd0) begin
            mul_done  = 1'b1;
            state_nxt = RUN;
          end else begin
            mul_cnt_nxt = mul_cnt - 4'd1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= sat_inc(stall_cnt, !pc_write);
      flush_cnt <= sat_inc(flush_cnt, flush_evt);
    end
  end

  assign bus.pc_write_o    = pc_write;
  assign bus.ifid_write_o  = ifid_write;
  assign bus.if_flush_o    = if_flush;
  assign bus.idex_flush_o  = idex_flush;
  assign bus.idex_hold_o   = idex_hold;
  assign bus.exmem_flush_o = exmem_flush;
  assign bus.mul_done_o    = mul_done;
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.flush_cnt_o   = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance (MUL_CYCLES=4, CNT_W=16)
// and a small instance (MUL_CYCLES=1, CNT_W=4) for single-cycle multiply and saturation.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  pipe_hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  pipe_hazard_ctrl #(.MUL_CYCLES(1), .CNT_W(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.idex_memread_i  = 1'b0;  bus.idex_rd_i = 5'd0;
    bus.ifid_rs_i       = 5'd0;  bus.ifid_rt_i = 5'd0;
    bus.ifid_uses_rt_i  = 1'b0;  bus.branch_taken_i = 1'b0;
    bus.mul_start_i     = 1'b0;
    bus4.idex_memread_i = 1'b0;  bus4.idex_rd_i = 5'd0;
    bus4.ifid_rs_i      = 5'd0;  bus4.ifid_rt_i = 5'd0;
    bus4.ifid_uses_rt_i = 1'b0;  bus4.branch_taken_i = 1'b0;
    bus4.mul_start_i    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    rst = 1'b1;
    bus.idex_memread_i = 1'b1; bus.idex_rd_i = 5'd8; bus.ifid_rs_i = 5'd8;
    bus.branch_taken_i = 1'b1; bus.mul_start_i = 1'b1;
    #1;
    ctl = {bus.pc_write_o, bus.ifid_write_o, bus.if_flush_o, bus.idex_flush_o,
           bus.idex_hold_o, bus.exmem_flush_o, bus.mul_done_o};
    checks++;
    if (ctl !== 7'b1000000) begin
      errors++; $display("FAIL reset_outputs got %b want 1000000", ctl);
    end
    tick();
    tick();
    checks++;
    if (bus.stall_cnt_o !== 16'd0 || bus.flush_cnt_o !== 16'd0) begin
      errors++; $display("FAIL reset_counters got stall=%0d flush=%0d want 0 0", bus.stall_cnt_o, bus.flush_cnt_o);
    end
    idle();
    rst = 1'b0;
    #1;
    ctl = {bus.pc_write_o, bus.ifid_write_o, bus.if_flush_o, bus.idex_flush_o,
           bus.idex_hold_o, bus.exmem_flush_o, bus.mul_done_o};
    checks++;
    if (ctl !== 7'b1000000) begin
      errors++; $display("FAIL run_idle got %b want 1000000", ctl);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.idex_memread_i = 1'b1; bus.idex_rd_i = 5'd8; bus.ifid_rs_i = 5'd8;
    #1;
    checks++;
    if ({bus.pc_write_o, bus.ifid_write_o, bus.idex_flush_o, bus.if_flush_o} !== 4'b0110) begin
      errors++; $display("FAIL load_use_ctl got %b want 0110",
                         {bus.pc_write_o, bus.ifid_write_o, bus.idex_flush_o, bus.if_flush_o});
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.stall_cnt_o !== 16'd1 || bus.pc_write_o !== 1'b1) begin
      errors++; $display("FAIL load_use_cnt got stall=%0d pc_write=%b want 1 1", bus.stall_cnt_o, bus.pc_write_o);
    end
  endtask

  task automatic test_zero_rt();
    do_reset();
    bus.idex_memread_i = 1'b1; bus.idex_rd_i = 5'd0; bus.ifid_rs_i = 5'd0;
    #1;
    checks++;
    if (bus.pc_write_o !== 1'b1) begin
      errors++; $display("FAIL zero_reg got pc_write=%b want 1", bus.pc_write_o);
    end
    bus.idex_rd_i = 5'd9; bus.ifid_rs_i = 5'd1; bus.ifid_rt_i = 5'd9; bus.ifid_uses_rt_i = 1'b0;
    #1;
    checks++;
    if (bus.pc_write_o !== 1'b1) begin
      errors++; $display("FAIL rt_unused got pc_write=%b want 1", bus.pc_write_o);
    end
    tick();
    bus.ifid_uses_rt_i = 1'b1;
    #1;
    checks++;
    if (bus.pc_write_o !== 1'b0 || bus.idex_flush_o !== 1'b1) begin
      errors++; $display("FAIL rt_used got pc_write=%b idex_flush=%b want 0 1", bus.pc_write_o, bus.idex_flush_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.stall_cnt_o !== 16'd1) begin
      errors++; $display("FAIL rt_cnt got %0d want 1", bus.stall_cnt_o);
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    bus.idex_memread_i = 1'b1; bus.idex_rd_i = 5'd8; bus.ifid_rs_i = 5'd8;
    bus.branch_taken_i = 1'b1; bus.mul_start_i = 1'b1;
    #1;
    checks++;
    if ({bus.if_flush_o, bus.idex_flush_o, bus.pc_write_o, bus.ifid_write_o} !== 4'b1110) begin
      errors++; $display("FAIL branch_ctl got %b want 1110",
                         {bus.if_flush_o, bus.idex_flush_o, bus.pc_write_o, bus.ifid_write_o});
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.flush_cnt_o !== 16'd1 || bus.stall_cnt_o !== 16'd0) begin
      errors++; $display("FAIL branch_cnt got flush=%0d stall=%0d want 1 0", bus.flush_cnt_o, bus.stall_cnt_o);
    end
    checks++;
    if (bus.idex_hold_o !== 1'b0 || bus.pc_write_o !== 1'b1) begin
      errors++; $display("FAIL branch_no_mul got hold=%b pc_write=%b want 0 1", bus.idex_hold_o, bus.pc_write_o);
    end
  endtask

  task automatic test_mul();
    do_reset();
    bus.mul_start_i = 1'b1;
    #1;
    checks++;
    if (bus.pc_write_o !== 1'b1 || bus.mul_done_o !== 1'b0) begin
      errors++; $display("FAIL mul_t got pc_write=%b done=%b want 1 0", bus.pc_write_o, bus.mul_done_o);
    end
    tick();
    bus.mul_start_i = 1'b0;
    #1;
    checks++;
    if ({bus.pc_write_o, bus.ifid_write_o, bus.idex_hold_o, bus.exmem_flush_o, bus.mul_done_o} !== 5'b01110) begin
      errors++; $display("FAIL mul_t1 got %b want 01110",
                         {bus.pc_write_o, bus.ifid_write_o, bus.idex_hold_o, bus.exmem_flush_o, bus.mul_done_o});
    end
    tick();
    bus.branch_taken_i = 1'b1; bus.mul_start_i = 1'b1;
    bus.idex_memread_i = 1'b1; bus.idex_rd_i = 5'd8; bus.ifid_rs_i = 5'd8;
    #1;
    checks++;
    if ({bus.pc_write_o, bus.if_flush_o, bus.idex_flush_o, bus.mul_done_o} !== 4'b0000) begin
      errors++; $display("FAIL mul_t2 got %b want 0000",
                         {bus.pc_write_o, bus.if_flush_o, bus.idex_flush_o, bus.mul_done_o});
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.mul_done_o !== 1'b1 || bus.pc_write_o !== 1'b0) begin
      errors++; $display("FAIL mul_t3 got done=%b pc_write=%b want 1 0", bus.mul_done_o, bus.pc_write_o);
    end
    tick();
    checks++;
    if (bus.mul_done_o !== 1'b0 || bus.pc_write_o !== 1'b1 || bus.idex_hold_o !== 1'b0) begin
      errors++; $display("FAIL mul_t4 got done=%b pc_write=%b hold=%b want 0 1 0",
                         bus.mul_done_o, bus.pc_write_o, bus.idex_hold_o);
    end
    checks++;
    if (bus.stall_cnt_o !== 16'd3 || bus.flush_cnt_o !== 16'd0) begin
      errors++; $display("FAIL mul_cnt got stall=%0d flush=%0d want 3 0", bus.stall_cnt_o, bus.flush_cnt_o);
    end
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    bus.mul_start_i = 1'b1;
    tick();
    bus.mul_start_i = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mul_done_o !== 1'b0 || bus.pc_write_o !== 1'b1) begin
      errors++; $display("FAIL rstmul_t2 got done=%b pc_write=%b want 0 1", bus.mul_done_o, bus.pc_write_o);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mul_done_o !== 1'b0 || bus.pc_write_o !== 1'b1 || bus.idex_hold_o !== 1'b0) begin
      errors++; $display("FAIL rstmul_t3 got done=%b pc_write=%b hold=%b want 0 1 0",
                         bus.mul_done_o, bus.pc_write_o, bus.idex_hold_o);
    end
    checks++;
    if (bus.stall_cnt_o !== 16'd0 || bus.flush_cnt_o !== 16'd0) begin
      errors++; $display("FAIL rstmul_cnt got stall=%0d flush=%0d want 0 0", bus.stall_cnt_o, bus.flush_cnt_o);
    end
    tick();
    checks++;
    if (bus.mul_done_o !== 1'b0 || bus.pc_write_o !== 1'b1) begin
      errors++; $display("FAIL rstmul_t4 got done=%b pc_write=%b want 0 1", bus.mul_done_o, bus.pc_write_o);
    end
  endtask

  task automatic test_mul_one();
    do_reset();
    bus4.mul_start_i = 1'b1;
    #1;
    checks++;
    if (bus4.mul_done_o !== 1'b1 || bus4.pc_write_o !== 1'b1) begin
      errors++; $display("FAIL mul1_done got done=%b pc_write=%b want 1 1", bus4.mul_done_o, bus4.pc_write_o);
    end
    tick();
    bus4.mul_start_i = 1'b0;
    #1;
    checks++;
    if (bus4.mul_done_o !== 1'b0 || bus4.pc_write_o !== 1'b1 || bus4.stall_cnt_o !== 4'd0) begin
      errors++; $display("FAIL mul1_after got done=%b pc_write=%b stall=%0d want 0 1 0",
                         bus4.mul_done_o, bus4.pc_write_o, bus4.stall_cnt_o);
    end
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    bus4.idex_memread_i = 1'b1; bus4.idex_rd_i = 5'd8; bus4.ifid_rs_i = 5'd8;
    for (int i = 1; i <= 20; i++) begin
      tick();
      want = (i > 15) ? 15 : i;
      checks++;
      if (bus4.stall_cnt_o !== want[3:0]) begin
        errors++; $display("FAIL sat_cycle%0d got %0d want %0d", i, bus4.stall_cnt_o, want);
      end
    end
    idle();
    tick();
    checks++;
    if (bus4.stall_cnt_o !== 4'd15) begin
      errors++; $display("FAIL sat_hold got %0d want 15", bus4.stall_cnt_o);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    test_reset();
    test_load_use();
    test_zero_rt();
    test_branch_priority();
    test_mul();
    test_reset_mid_mul();
    test_mul_one();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
